// File: rtl/am_bank_dp.sv
// Dual-port AM bank: P lanes x W bits per row, per-lane/per-byte masked writes,
// registered reads, post-reset clear sequencer and same-row write collision counter.
module am_bank_dp #(
   parameter int P     = 64,
   parameter int W     = 8,
   parameter int AW    = 3,
   parameter int DEPTH = 8,
   parameter int CW    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [AW-1:0]        addr0,
   input  logic                 cs0,
   input  logic                 rw0,
   input  logic [P*W-1:0]       wdata0,
   input  logic [P*W/8-1:0]     byteenable0,
   input  logic [P-1:0]         bank_cs0,
   output logic [P*W-1:0]       rdata0,
   input  logic [AW-1:0]        addr1,
   input  logic                 cs1,
   input  logic                 rw1,
   input  logic [P*W-1:0]       wdata1,
   input  logic [P*W/8-1:0]     byteenable1,
   input  logic [P-1:0]         bank_cs1,
   output logic [P*W-1:0]       rdata1,
   output logic                 init_done,
   output logic [CW-1:0]        wr_collision_cnt
);

   localparam int NB  = P*W/8;
   localparam int BPL = W/8;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t            state, state_nx;
   logic [AW-1:0]     clear_ptr, clear_ptr_nx;
   logic [P*W-1:0]    mem [DEPTH];

   logic              act;
   logic              we0, we1, re0, re1, collide;
   logic [NB-1:0]     wmask0, wmask1;
   logic [P*W-1:0]    lmask0, lmask1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= CLEAR;
         clear_ptr <= '0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nx;
         clear_ptr <= clear_ptr_nx;
         init_done <= (state_nx == RUN);
      end
   end

   always_comb begin
      state_nx     = state;
      clear_ptr_nx = clear_ptr;
      case (state)
         CLEAR: begin
            clear_ptr_nx = clear_ptr + AW'(1);
            if (clear_ptr == AW'(DEPTH-1))
               state_nx = RUN;
         end
         RUN:     state_nx = RUN;
         default: state_nx = CLEAR;
      endcase
   end

   always_comb begin
      act = (state == RUN) && !rst;
      we0 = act && cs0 && rw0;
      we1 = act && cs1 && rw1;
      re0 = act && cs0 && !rw0;
      re1 = act && cs1 && !rw1;
      wmask0 = '0;
      wmask1 = '0;
      lmask0 = '0;
      lmask1 = '0;
      for (int unsigned b = 0; b < NB; b++) begin
         wmask0[b] = byteenable0[b] && bank_cs0[b/BPL];
         wmask1[b] = byteenable1[b] && bank_cs1[b/BPL];
      end
      for (int unsigned l = 0; l < P; l++) begin
         lmask0[l*W +: W] = {W{bank_cs0[l]}};
         lmask1[l*W +: W] = {W{bank_cs1[l]}};
      end
      collide = we0 && we1 && (addr0 == addr1) && |(wmask0 & wmask1);
   end

   // Port1 bytes are assigned first so that overlapping port0 bytes win.
   always_ff @(posedge clk) begin
      if (state == CLEAR && !rst) begin
         mem[clear_ptr] <= '0;
      end else begin
         for (int unsigned b = 0; b < NB; b++)
            if (we1 && wmask1[b])
               mem[addr1][b*8 +: 8] <= wdata1[b*8 +: 8];
         for (int unsigned b = 0; b < NB; b++)
            if (we0 && wmask0[b])
               mem[addr0][b*8 +: 8] <= wdata0[b*8 +: 8];
      end
   end

   // Reads sample the pre-write contents, giving read-before-write on a shared row.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata0 <= '0;
         rdata1 <= '0;
      end else begin
         if (re0) rdata0 <= mem[addr0] & lmask0;
         if (re1) rdata1 <= mem[addr1] & lmask1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         wr_collision_cnt <= '0;
      else if (collide && wr_collision_cnt != '1)
         wr_collision_cnt <= wr_collision_cnt + CW'(1);
   end

endmodule

// File: doc/am_bank_dp.md
Name: am_bank_dp

Overview:
- Dual-port AM bank storage: the responder side of the bank interface driven by the AM access router. Two instances form AM Bank#0 and Bank#1.
- Each instance holds DEPTH rows of P lanes x W bits.
- Each port does a one-cycle-latency read or a masked write per cycle. Masking is per lane (bank_cs) and per byte (byteenable).
- After reset the array is cleared by an internal clear sequencer. A saturating counter records same-row write collisions between the two ports.

Parameters:
- P, 64, lanes per row
- W, 8, bits per lane; must be a multiple of 8
- AW, 3, row address width
- DEPTH, 8, rows; must equal 2**AW
- CW, 16, collision counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- addr0  in  AW  port0 row address
- cs0  in  1  port0 access enable, active-high
- rw0  in  1  port0 direction: read = 0, write = 1
- wdata0  in  P*W  port0 write data
- byteenable0  in  P*W/8  port0 byte write mask, active-high
- bank_cs0  in  P  port0 lane select, active-high
- rdata0  out  P*W  port0 read data
- addr1, cs1, rw1, wdata1, byteenable1, bank_cs1  in  same as port0  port1 request
- rdata1  out  P*W  port1 read data
- init_done  out  1  high once the clear sequence has finished
- wr_collision_cnt  out  CW  saturating count of same-row dual writes

Behaviour:
- Reset and clear:
  - rst=1 sets rdata0=rdata1=0, init_done=0, wr_collision_cnt=0, FSM->CLEAR, clear pointer=0.
  - rst=1 does not itself clear the array.
- FSM:
  - CLEAR: each cycle writes an all-zero row at clear_ptr, then clear_ptr++. On clear_ptr==DEPTH-1 it writes that row and moves to RUN. CLEAR therefore lasts exactly DEPTH cycles after rst deasserts.
  - RUN: init_done=1. Stays in RUN until rst.
  - rst asserted mid-CLEAR restarts the clear at row 0.
- Requests during CLEAR are ignored: no write, no read update, rdata holds 0, no collision count.
- Lane/byte mapping: byte b belongs to lane b/(W/8).
- Write (RUN, csN=1, rwN=1): byte b of row addrN takes wdataN[8b+7:8b] iff byteenableN[b] and bank_csN[lane(b)] are both set. The write is visible to a read issued in the next cycle.
- Read (RUN, csN=1, rwN=0):
  - rdataN is registered and valid on the cycle after the request (latency 1).
  - Lanes with bank_csN=0 return 0.
  - byteenable is ignored on reads.
- When csN=0, or csN=1 with rwN=1, rdataN holds its previous value.
- Read during write, either port to the same row in the same cycle: the read returns the old contents (read-before-write).
- Dual write to the same row:
  - Bytes enabled by only one port take that port's data.
  - Bytes enabled on both ports take port0 data.
  - wr_collision_cnt increments by 1 only if at least one byte overlaps. It saturates at 2**CW-1.
- Dual writes to different rows, and dual reads of any rows, proceed independently with no collision.
- A port with csN=1 and bank_csN all-zero: a write is a no-op; a read returns 0.
- Address is always in range (DEPTH=2**AW); there is no wrap-around logic.

Test Plan:
- Reset, then idle -> init_done=0 for 8 cycles after rst falls, =1 on the 9th. A read of any row on both ports returns 0 one cycle later.
- P=4, W=8, RUN: port0 writes row 3, wdata=0xAABBCCDD, byteenable=4'b1111, bank_cs=4'b0101. The next cycle port1 reads row 3 with bank_cs=4'hF -> rdata1=0x00BB00DD the following cycle.
- Same cycle: port0 writes row 2 = 0x11111111 with all enables, port1 reads row 2 (prior content 0) -> rdata1=0. A re-read next cycle returns 0x11111111.
- Same cycle both ports write row 5: port0 0xAAAAAAAA, byteenable 4'b0011; port1 0xBBBBBBBB, byteenable 4'b0110; bank_cs all set -> row 5 = 0x00BBAAAA and wr_collision_cnt=1. Repeating with byteenable 4'b1100 / 4'b0011 leaves the count at 1.
- Issue reads during CLEAR, and assert rst at clear cycle 4 -> rdata stays 0, no writes land, and init_done rises exactly 8 cycles after the second rst deassertion.
- CW=2: four overlapping dual writes -> wr_collision_cnt reads 1, 2, 3, 3 (saturates).
